// File: rtl/bcd_scan_display_if.sv
// Bus between the remote-control datapath and the multiplexed BCD display:
// value/strobe/enable in, conversion status and shared segment/select lines out.
interface bcd_scan_display_if #(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
);
  logic [WIDTH-1:0] in;
  logic             load;
  logic             enable;
  logic             busy;
  logic             ovf;
  logic [6:0]       seg;
  logic [DIGITS:0]  an;

  modport master (output in, load, enable, input busy, ovf, seg, an);
  modport slave  (input in, load, enable, output busy, ovf, seg, an);
endinterface

// File: rtl/bcd_scan_display.sv
// Sign-magnitude to BCD converter (double-dabble, one bit per clock) driving a
// scanned common-anode display. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module bcd_scan_display #(
  parameter int WIDTH    = 9,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1000
) (
  input logic               clk,
  input logic               rst,
  bcd_scan_display_if.slave bus
);
  localparam int M     = WIDTH - 1;
  localparam int BCD_N = (DIGITS > (M + 2) / 3) ? DIGITS : (M + 2) / 3;
  localparam int BCD_W = 4 * BCD_N;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS + 1);
  localparam int BIT_W = $clog2(M + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_E     = 7'b0110000;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 7'b0000001;
      4'd1:    digit_seg = 7'b1001111;
      4'd2:    digit_seg = 7'b0010010;
      4'd3:    digit_seg = 7'b0000110;
      4'd4:    digit_seg = 7'b1001100;
      4'd5:    digit_seg = 7'b0100100;
      4'd6:    digit_seg = 7'b0100000;
      4'd7:    digit_seg = 7'b0001111;
      4'd8:    digit_seg = 7'b0000000;
      4'd9:    digit_seg = 7'b0000100;
      default: digit_seg = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int n = 0; n < BCD_N; n++)
      if (r[4*n +: 4] >= 4'd5) r[4*n +: 4] = r[4*n +: 4] + 4'd3;
    return r;
  endfunction

  logic             busy_q;
  logic [BIT_W-1:0] bitcnt_p0;
  logic [M-1:0]     mag_p0;
  logic [BCD_W-1:0] bcd_p0;
  logic             neg_p0, nz_p0;
  logic [BCD_W-1:0] bcd_adj, bcd_step;
  logic [4*DIGITS-1:0] disp_bcd_p1;
  logic             disp_neg_p1, ovf_p1;
  logic             accept;

  assign accept   = bus.load && !busy_q;
  assign bcd_adj  = dd_adjust(bcd_p0);
  assign bcd_step = {bcd_adj[BCD_W-2:0], mag_p0[M-1]};

  // Stage p0: capture and shift-and-add-3 datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      mag_p0 <= bus.in[M-1:0];
      neg_p0 <= bus.in[M];
      nz_p0  <= |bus.in[M-1:0];
      bcd_p0 <= '0;
    end else if (busy_q) begin
      mag_p0 <= mag_p0 << 1;
      bcd_p0 <= bcd_step;
    end
  end

  // Stage p1: conversion control and committed display value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= 1'b0;
      bitcnt_p0   <= '0;
      disp_bcd_p1 <= '0;
      disp_neg_p1 <= 1'b0;
      ovf_p1      <= 1'b0;
    end else if (accept) begin
      busy_q    <= 1'b1;
      bitcnt_p0 <= '0;
    end else if (busy_q) begin
      bitcnt_p0 <= bitcnt_p0 + 1'b1;
      if (bitcnt_p0 == BIT_W'(M - 1)) begin
        busy_q      <= 1'b0;
        disp_bcd_p1 <= bcd_step[4*DIGITS-1:0];
        disp_neg_p1 <= neg_p0 && nz_p0;
        ovf_p1      <= |(bcd_step >> (4 * DIGITS));
      end
    end
  end

  logic [6:0] pos_code [0:DIGITS];
  logic [3:0] dig;
`ifdef LEADING_ZERO_BLANK_EN
  logic       nz_seen;
`endif

  always_comb begin
    dig = '0;
`ifdef LEADING_ZERO_BLANK_EN
    nz_seen = 1'b0;
`endif
    // Walk from the most significant digit so leading-zero state is known per position
    for (int p = DIGITS - 1; p >= 0; p--) begin
      dig = disp_bcd_p1[4*p +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      nz_seen = nz_seen || (dig != 4'd0);
      if (ovf_p1)                   pos_code[p] = SEG_E;
      else if (!nz_seen && p != 0)  pos_code[p] = SEG_BLANK;
      else                          pos_code[p] = digit_seg(dig);
`else
      pos_code[p] = ovf_p1 ? SEG_E : digit_seg(dig);
`endif
    end
    pos_code[DIGITS] = disp_neg_p1 ? SEG_MINUS : SEG_BLANK;
  end

  logic [CNT_W-1:0] scan_cnt;
  logic [IDX_W-1:0] idx, nidx;
  logic [6:0]       next_code, slot_seg_p2, seg_q;
  logic [DIGITS:0]  an_next, an_q;
  logic             wrap;

  assign wrap = (scan_cnt == CNT_W'(SCAN_DIV - 1));

  always_comb begin
    nidx      = (idx == IDX_W'(DIGITS)) ? '0 : idx + 1'b1;
    next_code = SEG_BLANK;
    an_next   = '1;
    for (int p = 0; p <= DIGITS; p++) begin
      if (nidx == IDX_W'(p)) next_code = pos_code[p];
      if (idx == IDX_W'(p))  an_next[p] = 1'b0;
    end
  end

  // Stage p2: scan position, per-slot segment latch and registered pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt    <= '0;
      idx         <= '0;
      slot_seg_p2 <= digit_seg(4'd0);
      seg_q       <= SEG_BLANK;
      an_q        <= '1;
    end else begin
      scan_cnt <= wrap ? '0 : scan_cnt + 1'b1;
      if (wrap) begin
        idx         <= nidx;
        slot_seg_p2 <= next_code;
      end
      seg_q <= bus.enable ? slot_seg_p2 : SEG_BLANK;
      an_q  <= bus.enable ? an_next : '1;
    end
  end

  assign bus.busy = busy_q;
  assign bus.ovf  = ovf_p1;
  assign bus.seg  = seg_q;
  assign bus.an   = an_q;
endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display: a 3-digit and a 2-digit instance with a short scan period.
module tb_bcd_scan_display;
  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110, S5 = 7'b0100100;
  localparam logic [6:0] S7 = 7'b0001111, S9 = 7'b0000100;
  localparam logic [6:0] SE = 7'b0110000, SB = 7'b1111111, SM = 7'b1111110;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = SB;
`else
  localparam logic [6:0] LZ = S0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   tests = 0, failed = 0;

  bcd_scan_display_if #(.WIDTH(9), .DIGITS(3)) d3 ();
  bcd_scan_display_if #(.WIDTH(9), .DIGITS(2)) d2 ();

  bcd_scan_display #(.WIDTH(9), .DIGITS(3), .SCAN_DIV(4)) u3 (.clk(clk), .rst(rst), .bus(d3));
  bcd_scan_display #(.WIDTH(9), .DIGITS(2), .SCAN_DIV(4)) u2 (.clk(clk), .rst(rst), .bus(d2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_load(input logic [8:0] v);
    @(negedge clk);
    d3.in = v; d2.in = v; d3.load = 1'b1; d2.load = 1'b1;
    @(negedge clk);
    d3.load = 1'b0; d2.load = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((d3.busy || d2.busy) && n < 50) begin @(negedge clk); n++; end
    check({tag, "_idle"}, 32'(d3.busy || d2.busy), 0);
  endtask

  task automatic scan3(input string tag, input logic [6:0] e0, e1, e2, e3);
    logic [6:0] e [4];
    logic [3:0] ea;
    int n;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    repeat (20) @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      ea = ~(4'b0001 << p);
      n = 0;
      while (d3.an !== ea && n < 20) begin @(negedge clk); n++; end
      check($sformatf("%s_an%0d", tag, p), 32'(d3.an), 32'(ea));
      check($sformatf("%s_seg%0d", tag, p), 32'(d3.seg), 32'(e[p]));
    end
  endtask

  task automatic scan2(input string tag, input logic [6:0] e0, e1, e2);
    logic [6:0] e [3];
    logic [2:0] ea;
    int n;
    e[0] = e0; e[1] = e1; e[2] = e2;
    repeat (16) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      ea = ~(3'b001 << p);
      n = 0;
      while (d2.an !== ea && n < 16) begin @(negedge clk); n++; end
      check($sformatf("%s_an%0d", tag, p), 32'(d2.an), 32'(ea));
      check($sformatf("%s_seg%0d", tag, p), 32'(d2.seg), 32'(e[p]));
    end
  endtask

  initial begin
    int n, i;
    logic [3:0] prev;
    logic [6:0] zero_code [4];
    zero_code[0] = S0; zero_code[1] = LZ; zero_code[2] = LZ; zero_code[3] = SB;

    rst = 1'b1;
    d3.in = '0; d3.load = 1'b0; d3.enable = 1'b1;
    d2.in = '0; d2.load = 1'b0; d2.enable = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(d3.busy), 0);
    check("rst_ovf", 32'(d3.ovf), 0);
    check("rst_seg", 32'(d3.seg), 32'h7F);
    check("rst_an", 32'(d3.an), 32'hF);
    rst = 1'b0;
    scan3("zero0", S0, LZ, LZ, SB);

    // 123: busy for exactly M=8 cycles
    start_load(9'd123);
    check("b123_busy_hi", 32'(d3.busy), 1);
    n = 0;
    while (d3.busy && n < 50) begin @(negedge clk); n++; end
    check("b123_busy_len", n, 8);
    check("b123_ovf", 32'(d3.ovf), 0);
    scan3("v123", S3, S2, S1, SB);

    // -255 on both widths
    start_load(9'h1FF);
    wait_idle("m255");
    check("m255_ovf3", 32'(d3.ovf), 0);
    check("m255_ovf2", 32'(d2.ovf), 1);
    scan3("m255", S5, S5, S2, SM);
    scan2("m255d2", SE, SE, SM);

    // negative zero shows as positive zero
    start_load(9'h100);
    wait_idle("nz");
    scan3("negz", S0, LZ, LZ, SB);

    // 100 overflows two digits; 99 does not
    start_load(9'd100);
    wait_idle("v100");
    check("v100_ovf2", 32'(d2.ovf), 1);
    check("v100_ovf3", 32'(d3.ovf), 0);
    scan2("v100d2", SE, SE, SB);
    scan3("v100", S0, S0, S1, SB);
    start_load(9'd99);
    wait_idle("v99");
    check("v99_ovf2", 32'(d2.ovf), 0);
    scan2("v99d2", S9, S9, SB);
    scan3("v99", S9, S9, LZ, SB);

    // load during busy is ignored
    @(negedge clk);
    d3.in = 9'd200; d2.in = 9'd200; d3.load = 1'b1; d2.load = 1'b1;
    @(negedge clk);
    d3.load = 1'b0; d2.load = 1'b0;
    n = 0;
    while (d3.busy && n < 50) begin
      if (n == 2) begin
        d3.in = 9'd77; d2.in = 9'd77; d3.load = 1'b1; d2.load = 1'b1;
      end else begin
        d3.load = 1'b0; d2.load = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    d3.load = 1'b0; d2.load = 1'b0;
    check("ign_busy_len", n, 8);
    @(negedge clk);
    check("ign_no_restart", 32'(d3.busy), 0);
    scan3("ign", S0, S0, S2, SB);

    // async reset mid-conversion
    start_load(9'd255);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("amid_busy", 32'(d3.busy), 0);
    check("amid_seg", 32'(d3.seg), 32'h7F);
    check("amid_an", 32'(d3.an), 32'hF);
    @(negedge clk);
    rst = 1'b0;
    scan3("postrst", S0, LZ, LZ, SB);

    // enable: find a slot start, blank for 10 cycles, resume two slots later
    prev = d3.an;
    n = 0;
    do begin @(negedge clk); n++; end while (d3.an === prev && n < 20);
    i = 0;
    for (int p = 0; p < 4; p++) if (d3.an[p] == 1'b0) i = p;
    d3.enable = 1'b0; d2.enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0 || c == 9) begin
        check($sformatf("dis_seg%0d", c), 32'(d3.seg), 32'h7F);
        check($sformatf("dis_an%0d", c), 32'(d3.an), 32'hF);
      end
    end
    d3.enable = 1'b1; d2.enable = 1'b1;
    @(negedge clk);
    check("reen_an", 32'(d3.an), 32'(4'(~(4'b0001 << ((i + 2) % 4)))));
    check("reen_seg", 32'(d3.seg), 32'(zero_code[(i + 2) % 4]));

    // single digit value, leading positions depend on blanking build
    start_load(9'd7);
    wait_idle("v7");
    scan3("v7", S7, LZ, LZ, SB);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
Sequential, parametrised successor to the three-digit combinational BCD/7-segment decoder. It captures a sign-magnitude binary value on a load strobe and converts it to BCD with an iterative shift-and-add-3 (double-dabble) engine, one bit per clock. It then drives a time-multiplexed common-anode display of DIGITS magnitude digits plus one sign digit. It sits between the remote-control datapath and the board 7-segment pins, and replaces per-digit static segment buses with one shared segment bus plus digit selects.

Parameters:
WIDTH, 9, input width in bits; bit WIDTH-1 is the sign, bits WIDTH-2:0 are the magnitude (M = WIDTH-1).
DIGITS, 3, number of decimal magnitude digits displayed (1..6).
SCAN_DIV, 1000, clock cycles each digit position stays selected (>=2).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in  input  WIDTH  sign-magnitude value to display.
load  input  1  single-cycle request to convert `in`.
enable  input  1  display enable; low blanks the outputs but conversion continues.
busy  output  1  high while a conversion is in progress.
ovf  output  1  high when the last converted magnitude exceeds 10^DIGITS-1.
seg  output  7  shared segments, active-low, bit6=a ... bit0=g.
an  output  DIGITS+1  digit selects, active-low; an[0]=units, an[DIGITS]=sign position.

Behaviour:
- Reset (async, rst=1):
  - busy=0, ovf=0, seg=7'b1111111, an all ones.
  - Display registers hold positive zero.
  - Scan counter and digit index are 0.
  - Any conversion in progress is aborted immediately.
- Handshake:
  - load is sampled only when busy=0. load while busy=1 is ignored; no queueing.
  - At edge k with load=1 and busy=0: capture in, clear the BCD shift register, set busy=1.
  - Edges k+1..k+M: one double-dabble step per edge. Each BCD nibble >=5 has 3 added, then the whole register shifts left 1.
  - At edge k+M: commit the digits, sign and ovf to the display registers, and clear busy. busy is high for exactly M cycles.
  - A new load is accepted on the cycle busy is low. Back-to-back conversions therefore cost M+1 cycles each.
- The internal BCD register is wide enough for the full M-bit magnitude. ovf=1 when any nibble above DIGITS-1 is nonzero after conversion.
- Sign:
  - The sign position shows minus (7'b1111110) when the sign bit is 1 and the magnitude is nonzero.
  - Otherwise it shows blank (7'b1111111). Negative zero displays as positive zero.
- Digit codes (active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- When ovf=1, every magnitude position shows E (7'b0110000). The sign position still follows the sign rule.
- Scan:
  - The counter counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the digit index advances 0..DIGITS and wraps to 0.
  - Exactly one an bit is low at a time, matching the digit index.
  - seg and an are registered, with no combinational path from in.
- Display updates from a commit take effect on the next scan slot; the scan position is not reset.
- enable=0: seg=all ones and an=all ones on the next edge. Scanning and conversion keep running. Re-enabling resumes at the current index.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: magnitude positions above the most significant nonzero digit show blank. The units digit always shows, so zero displays as a single 0. The minus sign stays at the sign position. Blanking is not applied when ovf=1.
- Undefined: all DIGITS positions are always shown, including leading zeros.

Test Plan:
- Defaults with SCAN_DIV=4: in=9'd123, load pulse -> busy high 8 cycles, ovf=0. Scan shows units 0000110, tens 0010010, hundreds 1001111, sign 1111111.
- in=9'h1FF (-255) -> digits 2,5,5, sign 1111110. in=9'h100 (-0) -> digits 0,0,0, sign blank.
- DIGITS=2, in=9'd100 -> ovf=1, both magnitude digits 0110000. Then in=9'd99 -> ovf=0, digits 9,9.
- load again 3 cycles after an accepted load -> ignored. busy still falls exactly 8 cycles after the first load, and the first value is displayed.
- rst asserted mid-conversion -> busy, seg and an reset the same cycle. After release, the display shows positive zero.
- enable=0 for 10 cycles -> seg and an all ones. Re-enable -> scanning resumes at the correct index. With LEADING_ZERO_BLANK_EN, in=9'd7 shows blank, blank, 7.
